// File: rtl/sh7604_irl_vec_responder.sv
// SH7604 external interrupt encoder: pending/mask registers, active-low IRL level
// output, and an external-vector responder on the VBUS side.
module sh7604_irl_vec_responder #(
    parameter logic [63:0] SRC_LVL  = 64'hFEDCBA9876543210,
    parameter logic [7:0]  VEC_BASE = 8'h40,
    parameter logic [7:0]  SPUR_VEC = 8'h18,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic [15:0] i_irq,
    input  logic        i_mask_we,
    input  logic [15:0] i_mask_di,
    output logic [15:0] o_mask,
    output logic [15:0] o_pend,
    output logic [3:0]  o_irl_n,
    input  logic [3:0]  i_vbus_a,
    input  logic        i_vbus_req,
    output logic [7:0]  o_vbus_di,
    output logic        o_vbus_wait
);

    // state | meaning
    // IDLE  | waiting for a vector fetch request
    // LOOK  | level captured, wait counter running; lookup fires when it reaches 0
    // DONE  | vector valid on o_vbus_di; waits for the request to drop
    typedef enum logic [1:0] {ST_IDLE, ST_LOOK, ST_DONE} state_t;

    localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYC - 1);

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_lvl, w_lvl_nxt;
    logic [7:0]  r_vbus_di, w_di_nxt;
    logic [15:0] r_pend, r_mask;
    logic [3:0]  r_irl_n, w_irl_nxt;
    logic [15:0] w_cand, w_clr;
    logic [3:0]  w_best_lvl;
    logic        w_match_hit;
    logic [3:0]  w_match_idx;

    // Level-0 sources are never candidates, so a captured level of 0 can never match.
    always_comb begin
        w_cand      = '0;
        w_best_lvl  = '0;
        w_match_hit = 1'b0;
        w_match_idx = '0;
        for (int n = 0; n < 16; n++) begin
            w_cand[n] = r_pend[n] & ~r_mask[n] & (SRC_LVL[4*n +: 4] != 4'd0);
            if (w_cand[n] && (SRC_LVL[4*n +: 4] > w_best_lvl))
                w_best_lvl = SRC_LVL[4*n +: 4];
            if (w_cand[n] && !w_match_hit && (SRC_LVL[4*n +: 4] == r_lvl)) begin
                w_match_hit = 1'b1;
                w_match_idx = 4'(n);
            end
        end
        w_irl_nxt = (w_cand == 16'd0) ? 4'hF : ~w_best_lvl;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lvl_nxt   = r_lvl;
        w_di_nxt    = r_vbus_di;
        w_clr       = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_vbus_req) begin
                    w_lvl_nxt   = i_vbus_a;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ST_LOOK;
                end
            end
            ST_LOOK: begin
                if (r_cnt != 3'd0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else begin
                    if (w_match_hit) begin
                        w_di_nxt = VEC_BASE + {4'd0, w_match_idx};
                        w_clr    = 16'd1 << w_match_idx;
                    end else begin
                        w_di_nxt = SPUR_VEC;
                    end
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!i_vbus_req)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_lvl     <= '0;
            r_vbus_di <= '0;
            r_pend    <= '0;
            r_mask    <= 16'hFFFF;
            r_irl_n   <= 4'hF;
        end else if (i_ce) begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_lvl     <= w_lvl_nxt;
            r_vbus_di <= w_di_nxt;
            // a new request on the clearing edge wins over the acknowledge clear
            r_pend    <= (r_pend & ~w_clr) | i_irq;
            if (i_mask_we)
                r_mask <= i_mask_di;
            r_irl_n   <= w_irl_nxt;
        end
    end

    assign o_mask      = r_mask;
    assign o_pend      = r_pend;
    assign o_irl_n     = r_irl_n;
    assign o_vbus_di   = r_vbus_di;
    assign o_vbus_wait = i_vbus_req && (r_state != ST_DONE) && !i_rst;

endmodule

// File: tb/tb_sh7604_irl_vec_responder.sv
// Bench for sh7604_irl_vec_responder: directed vector table, hand-written fetch
// and reset sequences, then randomized traffic against a behavioural model.
module tb_sh7604_irl_vec_responder;

    localparam logic [63:0] LVL_A = 64'hFEDCBA9876543210;
    localparam logic [63:0] LVL_B = 64'hFEDCBA9861543610;  // src 2 and 7 both level 6
    localparam int WC_A = 2;
    localparam int WC_B = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [15:0] irq [2];
    logic        we  [2];
    logic [15:0] mdi [2];
    logic        req [2];
    logic [3:0]  va  [2];
    logic [15:0] pend [2];
    logic [15:0] mask [2];
    logic [3:0]  irl  [2];
    logic [7:0]  di   [2];
    logic        wt   [2];

    always #5 clk = ~clk;

    sh7604_irl_vec_responder #(.SRC_LVL(LVL_A), .WAIT_CYC(WC_A)) u_a (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_irq(irq[0]),
        .i_mask_we(we[0]), .i_mask_di(mdi[0]), .o_mask(mask[0]), .o_pend(pend[0]),
        .o_irl_n(irl[0]), .i_vbus_a(va[0]), .i_vbus_req(req[0]),
        .o_vbus_di(di[0]), .o_vbus_wait(wt[0]));

    sh7604_irl_vec_responder #(.SRC_LVL(LVL_B), .WAIT_CYC(WC_B)) u_b (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_irq(irq[1]),
        .i_mask_we(we[1]), .i_mask_di(mdi[1]), .o_mask(mask[1]), .o_pend(pend[1]),
        .o_irl_n(irl[1]), .i_vbus_a(va[1]), .i_vbus_req(req[1]),
        .o_vbus_di(di[1]), .o_vbus_wait(wt[1]));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference ----------------
    int          lvl_tab [2][16];
    int          wc      [2];
    logic [15:0] m_pend  [2];
    logic [15:0] m_mask  [2];
    logic [3:0]  m_irl   [2];
    logic [7:0]  m_di    [2];
    int          m_phase [2];   // 0 idle, 1 fetch in progress, 2 vector delivered
    int          m_rem   [2];   // CE edges left until the vector is delivered
    int          m_cap   [2];

    task automatic model_reset(input int k);
        m_pend[k] = 16'h0000; m_mask[k] = 16'hFFFF; m_irl[k] = 4'hF;
        m_di[k] = 8'h00; m_phase[k] = 0; m_rem[k] = 0; m_cap[k] = 0;
    endtask

    task automatic model_step(input int k);
        logic [15:0] cand, clr;
        int best;
        bit found;
        cand = '0; clr = '0; best = 0; found = 0;
        for (int i = 0; i < 16; i++)
            if (m_pend[k][i] && !m_mask[k][i] && lvl_tab[k][i] != 0) cand[i] = 1'b1;
        for (int i = 0; i < 16; i++)
            if (cand[i] && lvl_tab[k][i] > best) best = lvl_tab[k][i];
        if (m_phase[k] == 0) begin
            if (req[k]) begin
                m_cap[k] = int'(va[k]); m_rem[k] = wc[k]; m_phase[k] = 1;
            end
        end else if (m_phase[k] == 1) begin
            m_rem[k]--;
            if (m_rem[k] == 0) begin
                for (int i = 0; i < 16; i++)
                    if (!found && cand[i] && lvl_tab[k][i] == m_cap[k]) begin
                        found = 1; clr[i] = 1'b1; m_di[k] = 8'h40 + 8'(i);
                    end
                if (!found) m_di[k] = 8'h18;
                m_phase[k] = 2;
            end
        end else if (!req[k]) begin
            m_phase[k] = 0;
        end
        m_irl[k]  = (cand == 16'd0) ? 4'hF : ~4'(best);
        m_pend[k] = (m_pend[k] & ~clr) | irq[k];
        if (we[k]) m_mask[k] = mdi[k];
    endtask

    task automatic model_check(input int k);
        string s;
        s = (k == 0) ? "A" : "B";
        check({"rnd_pend_", s}, 32'(pend[k]), 32'(m_pend[k]));
        check({"rnd_mask_", s}, 32'(mask[k]), 32'(m_mask[k]));
        check({"rnd_irl_", s},  32'(irl[k]),  32'(m_irl[k]));
        check({"rnd_di_", s},   32'(di[k]),   32'(m_di[k]));
        check({"rnd_wait_", s}, 32'(wt[k]),   32'(!rst && req[k] && m_phase[k] != 2));
    endtask

    // ---------------- directed vector table (DUT A) ----------------
    typedef struct {
        logic [15:0] irq;
        logic        we;
        logic [15:0] mdi;
        logic        req;
        logic [3:0]  a;
        logic [15:0] e_pend;
        logic [15:0] e_mask;
        logic [3:0]  e_irl;
        logic        e_wait;
        logic [7:0]  e_di;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] i_irq, input logic i_we, input logic [15:0] i_mdi,
                                input logic i_req, input logic [3:0] i_a,
                                input logic [15:0] ep, input logic [15:0] em, input logic [3:0] ei,
                                input logic ew, input logic [7:0] ed);
        vec_t v;
        v.irq = i_irq; v.we = i_we; v.mdi = i_mdi; v.req = i_req; v.a = i_a;
        v.e_pend = ep; v.e_mask = em; v.e_irl = ei; v.e_wait = ew; v.e_di = ed;
        return v;
    endfunction

    vec_t tbl [29];

    task automatic fetch_b(input logic [3:0] lvl, input logic [7:0] exp_di, input logic [15:0] exp_pend);
        req[1] = 1'b1; va[1] = lvl;
        repeat (WC_B) begin
            tick();
            check("b_wait_hi", 32'(wt[1]), 32'd1);
        end
        tick();
        check("b_vec", 32'(di[1]), 32'(exp_di));
        check("b_pend", 32'(pend[1]), 32'(exp_pend));
        check("b_wait_lo", 32'(wt[1]), 32'd0);
        req[1] = 1'b0;
        tick();
    endtask

    logic [15:0] r_irq, r_mdi;
    logic        r_we, r_req;
    logic [3:0]  r_a;

    initial begin
        for (int k = 0; k < 2; k++) begin
            logic [63:0] t;
            t = (k == 0) ? LVL_A : LVL_B;
            for (int n = 0; n < 16; n++) lvl_tab[k][n] = int'(t[4*n +: 4]);
            irq[k] = '0; we[k] = 0; mdi[k] = '0; req[k] = 0; va[k] = '0;
            model_reset(k);
        end
        wc[0] = WC_A; wc[1] = WC_B;

        tbl[0]  = mk(16'h0000, 1, 16'h0000, 0, 4'd0, 16'h0000, 16'h0000, 4'hF, 0, 8'h00);
        tbl[1]  = mk(16'h0020, 0, 16'h0000, 0, 4'd0, 16'h0020, 16'h0000, 4'hF, 0, 8'h00);
        tbl[2]  = mk(16'h0000, 0, 16'h0000, 0, 4'd0, 16'h0020, 16'h0000, 4'hA, 0, 8'h00);
        tbl[3]  = mk(16'h0208, 1, 16'h0020, 0, 4'd0, 16'h0228, 16'h0020, 4'hA, 0, 8'h00);
        tbl[4]  = mk(16'h0000, 0, 16'h0000, 0, 4'd0, 16'h0228, 16'h0020, 4'h6, 0, 8'h00);
        tbl[5]  = mk(16'h0000, 0, 16'h0000, 1, 4'd9, 16'h0228, 16'h0020, 4'h6, 1, 8'h00);
        tbl[6]  = mk(16'h0000, 0, 16'h0000, 1, 4'd9, 16'h0228, 16'h0020, 4'h6, 1, 8'h00);
        tbl[7]  = mk(16'h0000, 0, 16'h0000, 1, 4'd9, 16'h0028, 16'h0020, 4'h6, 0, 8'h49);
        tbl[8]  = mk(16'h0000, 0, 16'h0000, 0, 4'd0, 16'h0028, 16'h0020, 4'hC, 0, 8'h49);
        tbl[9]  = mk(16'h0000, 0, 16'h0000, 1, 4'd4, 16'h0028, 16'h0020, 4'hC, 1, 8'h49);
        tbl[10] = mk(16'h0000, 0, 16'h0000, 1, 4'd4, 16'h0028, 16'h0020, 4'hC, 1, 8'h49);
        tbl[11] = mk(16'h0000, 0, 16'h0000, 1, 4'd4, 16'h0028, 16'h0020, 4'hC, 0, 8'h18);
        tbl[12] = mk(16'h0000, 0, 16'h0000, 0, 4'd0, 16'h0028, 16'h0020, 4'hC, 0, 8'h18);
        tbl[13] = mk(16'h0200, 0, 16'h0000, 0, 4'd0, 16'h0228, 16'h0020, 4'hC, 0, 8'h18);
        tbl[14] = mk(16'h0000, 0, 16'h0000, 1, 4'd9, 16'h0228, 16'h0020, 4'h6, 1, 8'h18);
        tbl[15] = mk(16'h0000, 0, 16'h0000, 1, 4'd9, 16'h0228, 16'h0020, 4'h6, 1, 8'h18);
        tbl[16] = mk(16'h0200, 0, 16'h0000, 1, 4'd9, 16'h0228, 16'h0020, 4'h6, 0, 8'h49);
        tbl[17] = mk(16'h0000, 0, 16'h0000, 0, 4'd0, 16'h0228, 16'h0020, 4'h6, 0, 8'h49);
        tbl[18] = mk(16'h0000, 0, 16'h0000, 1, 4'd3, 16'h0228, 16'h0020, 4'h6, 1, 8'h49);
        tbl[19] = mk(16'h0000, 0, 16'h0000, 0, 4'd3, 16'h0228, 16'h0020, 4'h6, 0, 8'h49);
        tbl[20] = mk(16'h0000, 0, 16'h0000, 0, 4'd3, 16'h0220, 16'h0020, 4'h6, 0, 8'h43);
        tbl[21] = mk(16'h0000, 0, 16'h0000, 0, 4'd0, 16'h0220, 16'h0020, 4'h6, 0, 8'h43);
        tbl[22] = mk(16'h0000, 0, 16'h0000, 1, 4'd0, 16'h0220, 16'h0020, 4'h6, 1, 8'h43);
        tbl[23] = mk(16'h0000, 0, 16'h0000, 1, 4'd0, 16'h0220, 16'h0020, 4'h6, 1, 8'h43);
        tbl[24] = mk(16'h0000, 0, 16'h0000, 1, 4'd0, 16'h0220, 16'h0020, 4'h6, 0, 8'h18);
        tbl[25] = mk(16'h0000, 0, 16'h0000, 1, 4'd0, 16'h0220, 16'h0020, 4'h6, 0, 8'h18);
        tbl[26] = mk(16'h0000, 0, 16'h0000, 0, 4'd0, 16'h0220, 16'h0020, 4'h6, 0, 8'h18);
        tbl[27] = mk(16'h0000, 1, 16'hFFFF, 0, 4'd0, 16'h0220, 16'hFFFF, 4'h6, 0, 8'h18);
        tbl[28] = mk(16'h0000, 0, 16'h0000, 0, 4'd0, 16'h0220, 16'hFFFF, 4'hF, 0, 8'h18);

        rst = 1'b1; ce = 1'b1;
        #12;
        check("rst_pend", 32'(pend[0]), 32'h0000);
        check("rst_mask", 32'(mask[0]), 32'hFFFF);
        check("rst_irl",  32'(irl[0]),  32'hF);
        check("rst_di",   32'(di[0]),   32'h00);
        check("rst_wait", 32'(wt[0]),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int r = 0; r < 29; r++) begin
            irq[0] = tbl[r].irq; we[0] = tbl[r].we; mdi[0] = tbl[r].mdi;
            req[0] = tbl[r].req; va[0] = tbl[r].a;
            tick();
            check($sformatf("tbl%0d_pend", r), 32'(pend[0]), 32'(tbl[r].e_pend));
            check($sformatf("tbl%0d_mask", r), 32'(mask[0]), 32'(tbl[r].e_mask));
            check($sformatf("tbl%0d_irl", r),  32'(irl[0]),  32'(tbl[r].e_irl));
            check($sformatf("tbl%0d_wait", r), 32'(wt[0]),   32'(tbl[r].e_wait));
            check($sformatf("tbl%0d_di", r),   32'(di[0]),   32'(tbl[r].e_di));
        end
        irq[0] = '0; we[0] = 0; req[0] = 0;

        // asynchronous reset in the middle of a lookup, request held throughout
        we[0] = 1; mdi[0] = 16'h0000;
        tick();
        we[0] = 0; req[0] = 1; va[0] = 4'd9;
        tick();
        tick();
        check("pre_rst_wait", 32'(wt[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_wait", 32'(wt[0]),   32'd0);
        check("arst_pend", 32'(pend[0]), 32'h0000);
        check("arst_mask", 32'(mask[0]), 32'hFFFF);
        check("arst_irl",  32'(irl[0]),  32'hF);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("relook_wait1", 32'(wt[0]), 32'd1);
        tick();
        check("relook_wait2", 32'(wt[0]), 32'd1);
        tick();
        check("relook_vec",  32'(di[0]), 32'h18);
        check("relook_wait", 32'(wt[0]), 32'd0);
        req[0] = 0;
        tick();

        // equal-level sources on DUT B: lowest index acknowledged first
        we[1] = 1; mdi[1] = 16'h0000; irq[1] = 16'h0084;
        tick();
        check("b_pend_set", 32'(pend[1]), 32'h0084);
        we[1] = 0; irq[1] = 16'h0000;
        tick();
        check("b_irl", 32'(irl[1]), 32'h9);
        fetch_b(4'd6, 8'h42, 16'h0080);
        fetch_b(4'd6, 8'h47, 16'h0000);
        check("b_irl_idle", 32'(irl[1]), 32'hF);

        // randomized traffic, both instances driven alike
        rst = 1'b1;
        model_reset(0); model_reset(1);
        tick();
        rst = 1'b0;
        r_req = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            ce    = ($urandom_range(0, 4) != 0);
            rst   = ($urandom_range(0, 299) == 0);
            r_irq = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom) : 16'h0000;
            r_we  = ($urandom_range(0, 15) == 0);
            r_mdi = 16'($urandom & $urandom);
            if ($urandom_range(0, 5) == 0) r_req = ~r_req;
            r_a   = 4'($urandom_range(0, 15));
            for (int k = 0; k < 2; k++) begin
                irq[k] = r_irq; we[k] = r_we; mdi[k] = r_mdi; req[k] = r_req; va[k] = r_a;
                if (rst) model_reset(k);
            end
            @(posedge clk);
            if (!rst && ce) begin
                model_step(0);
                model_step(1);
            end
            #1;
            model_check(0);
            model_check(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
